// File: rtl/hi_lo_muldiv_if.sv
// Bus between the control FSM and the HI/LO multiply/divide unit.
// The control side is the master and the unit is the slave.
interface hi_lo_muldiv_if #(
    parameter int unsigned SIZE = 32
);
    logic            START;
    logic [1:0]      OP;
    logic [SIZE-1:0] SRC_A;
    logic [SIZE-1:0] SRC_B;
    logic            HEN;
    logic            LEN;
    logic [SIZE-1:0] RD1;
    logic            BUSY;
    logic            DONE;
    logic            DIV_ZERO;
    logic [SIZE-1:0] hi;
    logic [SIZE-1:0] lo;

    modport master (
        output START, OP, SRC_A, SRC_B, HEN, LEN, RD1,
        input  BUSY, DONE, DIV_ZERO, hi, lo
    );

    modport slave (
        input  START, OP, SRC_A, SRC_B, HEN, LEN, RD1,
        output BUSY, DONE, DIV_ZERO, hi, lo
    );
endinterface

// File: rtl/hi_lo_muldiv.sv
// Iterative signed/unsigned multiply/divide unit that owns HI and LO.
// One radix-2 step per cycle over SIZE cycles, with a sign-fixup cycle at the end.
module hi_lo_muldiv #(
    parameter int unsigned SIZE = 32
) (
    input logic           CLK,
    input logic           RST,
    hi_lo_muldiv_if.slave bus
);
    localparam int unsigned CW = $clog2(SIZE);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t            state;
    state_t            state_d;
    logic              accept;
    logic              mt_ok;
    logic [CW-1:0]     cnt;
    logic [1:0]        op_q;
    logic [SIZE-1:0]   b_mag;
    logic [2*SIZE-1:0] acc;
    logic              neg_prod;
    logic              neg_rem;
    logic              div_zero_q;
    logic [SIZE-1:0]   hi_q;
    logic [SIZE-1:0]   lo_q;
    logic              busy_q;
    logic              done_q;
    logic              dz_q;

    logic              sgn_a;
    logic              sgn_b;
    logic [SIZE-1:0]   a_mag_in;
    logic [SIZE-1:0]   b_mag_in;
    logic [SIZE-1:0]   b_add;
    logic [SIZE:0]     mul_sum;
    logic [SIZE:0]     div_trial;
    logic [2*SIZE-1:0] acc_step;
    logic [2*SIZE-1:0] mul_res;
    logic [SIZE-1:0]   quo_res;
    logic [SIZE-1:0]   rem_res;

    always_comb begin
        state_d = state;
        accept  = 1'b0;
        unique case (state)
            IDLE: if (bus.START) begin
                state_d = RUN;
                accept  = 1'b1;
            end
            RUN:  if (cnt == '0) state_d = FIN;
            FIN:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mt_ok = (state == IDLE) && !bus.START;

    // Operand magnitudes and result signs; OP[0]=0 selects the signed variant.
    always_comb begin
        sgn_a    = !bus.OP[0] && bus.SRC_A[SIZE-1];
        sgn_b    = !bus.OP[0] && bus.SRC_B[SIZE-1];
        a_mag_in = sgn_a ? -bus.SRC_A : bus.SRC_A;
        b_mag_in = sgn_b ? -bus.SRC_B : bus.SRC_B;
    end

    // acc holds {upper, lower}: product halves for MULT, {remainder, dividend/quotient} for DIV.
    always_comb begin
        b_add     = acc[0] ? b_mag : '0;
        mul_sum   = {1'b0, acc[2*SIZE-1:SIZE]} + {1'b0, b_add};
        div_trial = acc[2*SIZE-1:SIZE-1] - {1'b0, b_mag};
        if (op_q[1]) begin
            if (div_trial[SIZE])
                acc_step = {acc[2*SIZE-2:0], 1'b0};
            else
                acc_step = {div_trial[SIZE-1:0], acc[SIZE-2:0], 1'b1};
        end else begin
            acc_step = {mul_sum, acc[SIZE-1:1]};
        end
        mul_res = neg_prod ? -acc : acc;
        quo_res = neg_prod ? -acc[SIZE-1:0] : acc[SIZE-1:0];
        rem_res = neg_rem ? -acc[2*SIZE-1:SIZE] : acc[2*SIZE-1:SIZE];
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt        <= '0;
            op_q       <= '0;
            b_mag      <= '0;
            acc        <= '0;
            neg_prod   <= 1'b0;
            neg_rem    <= 1'b0;
            div_zero_q <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dz_q       <= 1'b0;
        end else begin
            busy_q <= (state_d != IDLE);
            done_q <= (state == FIN);
            dz_q   <= (state == FIN) && div_zero_q;

            if (accept) begin
                op_q       <= bus.OP;
                acc        <= {{SIZE{1'b0}}, a_mag_in};
                b_mag      <= b_mag_in;
                neg_prod   <= sgn_a ^ sgn_b;
                neg_rem    <= sgn_a;
                div_zero_q <= bus.OP[1] && (bus.SRC_B == '0);
                cnt        <= CW'(SIZE - 1);
            end else if (state == RUN) begin
                acc <= acc_step;
                cnt <= cnt - CW'(1);
            end

            if (state == FIN) begin
                if (!div_zero_q) begin
                    if (op_q[1]) begin
                        hi_q <= rem_res;
                        lo_q <= quo_res;
                    end else begin
                        hi_q <= mul_res[2*SIZE-1:SIZE];
                        lo_q <= mul_res[SIZE-1:0];
                    end
                end
            end else if (mt_ok) begin
                if (bus.HEN) hi_q <= bus.RD1;
                if (bus.LEN) lo_q <= bus.RD1;
            end
        end
    end

    assign bus.BUSY     = busy_q;
    assign bus.DONE     = done_q;
    assign bus.DIV_ZERO = dz_q;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
endmodule

// File: tb/tb_hi_lo_muldiv.sv
// Scoreboard bench for hi_lo_muldiv at SIZE=32: expected HI/LO/flags and
// completion cycle are queued at issue and compared when DONE pulses.
module tb_hi_lo_muldiv;
    localparam int unsigned SIZE = 32;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   errors = 0;
    int   checks = 0;
    int   busy_cnt = 0;
    logic [31:0] exp_hi = '0;
    logic [31:0] exp_lo = '0;
    exp_t sb[$];

    hi_lo_muldiv_if #(.SIZE(SIZE)) bus ();

    hi_lo_muldiv #(.SIZE(SIZE)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        exp_t        e;
        longint      sa, sv, q, r;
        logic [63:0] p;
        sa   = longint'($signed(a));
        sv   = longint'($signed(b));
        e.dz = 1'b0;
        e.cyc = 0;
        e.hi = exp_hi;
        e.lo = exp_lo;
        case (op)
            2'b00: begin p = sa * sv; e.hi = p[63:32]; e.lo = p[31:0]; end
            2'b01: begin p = {32'b0, a} * {32'b0, b}; e.hi = p[63:32]; e.lo = p[31:0]; end
            default: begin
                if (b == 32'd0) begin
                    e.dz = 1'b1;
                end else if (op == 2'b10) begin
                    q = sa / sv;
                    r = sa % sv;
                    e.lo = q[31:0];
                    e.hi = r[31:0];
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        exp_hi = e.hi;
        exp_lo = e.lo;
        return e;
    endfunction

    // Called #1 after a rising edge (or at a falling edge); START is taken on the next edge.
    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input bit track, input bit hen);
        exp_t e;
        bus.START = 1'b1;
        bus.OP    = op;
        bus.SRC_A = a;
        bus.SRC_B = b;
        bus.HEN   = hen;
        bus.RD1   = 32'h55;
        if (track) begin
            e = model(op, a, b);
            e.cyc = cyc + SIZE + 2;
            sb.push_back(e);
        end
        @(posedge clk); #1;
        bus.START = 1'b0;
        bus.HEN   = 1'b0;
        bus.OP    = 2'($urandom);
        bus.SRC_A = $urandom;
        bus.SRC_B = $urandom;
    endtask

    task automatic drain();
        int n = 0;
        while ((sb.size() != 0 || bus.BUSY) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) begin
            check("drain_timeout", 1, 0);
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            busy_cnt = 0;
        end else begin
            if (bus.BUSY) busy_cnt++;
            if (bus.DIV_ZERO && !bus.DONE) check("dz_without_done", 1, 0);
            if (bus.DONE) begin
                if (sb.size() == 0) begin
                    check("spurious_done", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check("hi", bus.hi, e.hi);
                    check("lo", bus.lo, e.lo);
                    check("div_zero", bus.DIV_ZERO, e.dz);
                    check("latency", cyc, e.cyc);
                    check("busy_cycles", busy_cnt, SIZE + 1);
                    check("busy_with_done", bus.BUSY, 0);
                end
                busy_cnt = 0;
            end
        end
    end

    initial begin
        logic [1:0]  rop;
        logic [31:0] ra, rb;
        int          n;

        bus.START = 1'b0; bus.OP = '0; bus.SRC_A = '0; bus.SRC_B = '0;
        bus.HEN = 1'b0; bus.LEN = 1'b0; bus.RD1 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.BUSY, 0);
        check("rst_done", bus.DONE, 0);
        check("rst_dz", bus.DIV_ZERO, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1, 0);
        drain();
        check("mult_neg_hi", bus.hi, 32'hFFFF_FFFF);
        check("mult_neg_lo", bus.lo, 32'hFFFF_FFEB);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
        drain();
        check("multu_max_hi", bus.hi, 32'hFFFF_FFFE);
        check("multu_max_lo", bus.lo, 32'h0000_0001);
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0);
        drain();

        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1, 0);
        drain();
        check("div_neg_lo", bus.lo, 32'hFFFF_FFFD);
        check("div_neg_hi", bus.hi, 32'hFFFF_FFFF);

        // Back-to-back: second START on the edge right after FIN, while DONE is high.
        issue(2'b11, 32'd7, 32'd2, 1, 0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.DONE && n < 60);
        if (n >= 60) check("b2b_timeout", 1, 0);
        issue(2'b11, 32'd100, 32'd7, 1, 0);
        drain();

        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1, 0);
        drain();
        check("div_ovf_lo", bus.lo, 32'h8000_0000);
        check("div_ovf_hi", bus.hi, 32'h0);

        bus.HEN = 1'b1; bus.LEN = 1'b1; bus.RD1 = 32'h11;
        @(posedge clk); #1;
        bus.HEN = 1'b0; bus.LEN = 1'b0; bus.RD1 = '0;
        exp_hi = 32'h11; exp_lo = 32'h11;
        check("mt_hi", bus.hi, 32'h11);
        check("mt_lo", bus.lo, 32'h11);

        issue(2'b11, 32'd5, 32'd0, 1, 0);
        drain();
        check("divz_hi", bus.hi, 32'h11);
        check("divz_lo", bus.lo, 32'h11);

        // HEN alongside START in IDLE loses to START.
        issue(2'b10, 32'd9, 32'd0, 1, 1);
        drain();
        check("start_prio_hi", bus.hi, 32'h11);

        issue(2'b01, 32'd3, 32'd5, 1, 0);
        repeat (5) @(posedge clk);
        #1;
        bus.START = 1'b1; bus.OP = 2'b00; bus.SRC_A = 32'd7; bus.SRC_B = 32'd9;
        bus.HEN = 1'b1; bus.RD1 = 32'hAA;
        @(posedge clk); #1;
        bus.START = 1'b0; bus.HEN = 1'b0;
        drain();
        check("ignore_hi", bus.hi, 32'h0);
        check("ignore_lo", bus.lo, 32'd15);

        issue(2'b00, 32'd3, 32'd5, 0, 0);
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_hi = '0; exp_lo = '0;
        check("midrst_hi", bus.hi, 0);
        check("midrst_lo", bus.lo, 0);
        check("midrst_busy", bus.BUSY, 0);
        repeat (SIZE + 5) @(posedge clk);
        #1;
        issue(2'b11, 32'd100, 32'd7, 1, 0);
        drain();

        for (int i = 0; i < 6; i++) begin
            rop = 2'($urandom_range(0, 3));
            ra  = $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            issue(rop, ra, rb, 1, 0);
            drain();
        end

        check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/hi_lo_muldiv.md
# hi_lo_muldiv

Parametrised successor to the HI/LO register pair: an iterative multiply/divide unit that owns HI and LO. It executes signed and unsigned MULT/DIV over SIZE cycles and supports direct HI/LO writes (MTHI/MTLO). It sits beside the main ALU in the multicycle datapath. The control FSM stalls on BUSY and resumes on DONE; MFHI/MFLO read `hi`/`lo` directly.

## Interface
- SIZE, 32, operand and HI/LO register width; must be even and at least 4
- CLK  in  1  clock; all state updates on the rising edge
- RST  in  1  synchronous, active-high reset
- START  in  1  begin an operation; sampled only in IDLE
- OP  in  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU
- SRC_A  in  SIZE  multiplicand or dividend; latched on an accepted START
- SRC_B  in  SIZE  multiplier or divisor; latched on an accepted START
- HEN  in  1  write RD1 into hi (MTHI)
- LEN  in  1  write RD1 into lo (MTLO)
- RD1  in  SIZE  data for HEN/LEN
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle pulse: hi/lo updated by a completed operation
- DIV_ZERO  out  1  one-cycle pulse with DONE when a DIV/DIVU had divisor 0
- hi  out  SIZE  HI register
- lo  out  SIZE  LO register

## Operation
- FSM states and transitions:
  - IDLE -> RUN when START=1.
  - RUN -> FIN after exactly SIZE iterations; a counter runs SIZE-1 down to 0.
  - FIN -> IDLE unconditionally.
- On accepted START:
  - Latch OP.
  - Latch operand magnitudes: two's-complement negate when OP is signed and the MSB is 1.
  - Latch the result sign flags.
  - Latch the zero-divisor flag (SRC_B==0 with OP[1]=1).
- Multiply:
  - Radix-2 shift-add on magnitudes with a 2*SIZE product register.
  - In FIN, negate the 2*SIZE product if sign(A) xor sign(B) (signed only).
  - hi gets the upper SIZE bits; lo gets the lower SIZE bits.
- Divide:
  - Restoring divide on magnitudes: SIZE-bit quotient, SIZE-bit remainder.
  - Signed: quotient negated if sign(A) xor sign(B); remainder takes the sign of A.
  - lo gets the quotient; hi gets the remainder.
  - Most-negative / -1 gives lo=most-negative and hi=0 (quotient wraps). No flag is raised.
- Divide by zero:
  - Full latency still runs.
  - hi/lo are NOT written.
  - DIV_ZERO pulses together with DONE.
- HEN/LEN:
  - Honoured only in IDLE with START=0.
  - HEN and LEN may be asserted together: both registers get RD1 on the same edge.
  - Ignored in RUN/FIN and when START=1 in the same cycle (START has priority).
- START during RUN/FIN is ignored; the operation in flight is not restarted.
- SRC_A/SRC_B/OP may change freely after the START edge.

## Timing
- Reset (RST=1 at an edge) from any state, including mid-RUN:
  - State becomes IDLE.
  - hi=0, lo=0, BUSY=0, DONE=0, DIV_ZERO=0, counter=0.
  - The in-flight result is discarded.
- START sampled at edge E0:
  - BUSY=1 from after E0.
  - Iterations occur on edges E1..E_SIZE.
  - FIN edge E_{SIZE+1} writes hi/lo. After it BUSY=0 and DONE=1 (DIV_ZERO=1 if applicable) for exactly one cycle.
  - Total latency is SIZE+1 edges (33 for SIZE=32).
- A new START may be accepted on the edge immediately after FIN, while DONE is high. Issue-to-issue is therefore SIZE+2 cycles.
- HEN/LEN writes are visible on hi/lo the cycle after the edge.
- BUSY and DONE are registered. DONE=1 implies BUSY=0.

## Test plan
- MULT, SRC_A=0xFFFFFFFD (-3), SRC_B=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DONE pulses 33 edges after START; BUSY is high for 33 cycles.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001. MULT with the same operands -> hi=0, lo=1.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 7/2 -> lo=3, hi=1. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- HEN+LEN in IDLE with RD1=0x11 -> hi=lo=0x11. Then DIVU 5/0 -> hi=lo=0x11 unchanged, and DIV_ZERO and DONE both pulse at edge 33.
- Start MULTU 3*5. During RUN, assert START with new operands and HEN with RD1=0xAA. Both are ignored: result hi=0, lo=15.
- Start MULT 3*5 and assert RST at edge 10 -> next cycle hi=lo=0, BUSY=0, and no DONE pulse follows. A START issued after reset completes normally.
